// File: rtl/fir_seq_mac.sv
// fir_seq_mac: time-multiplexed FIR filter built around a single MAC.
// One input sample is accepted in IDLE, NUM_TAPS multiply-accumulate
// cycles run in MAC, and the rounded, saturated result is held in OUT
// until the downstream consumer takes it. The delay line is a circular
// register buffer and the coefficients live in a writable register file.
module fir_seq_mac #(
  parameter int NUM_TAPS = 11,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]      coef_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          sat,
  output logic                          busy
);

  localparam int AW = $clog2(NUM_TAPS);
  localparam int PW = DATA_W + COEF_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]   TAPS_EXT = (AW + 1)'(NUM_TAPS);

  // Half an output LSB; the shift-then-halve form yields zero when SHIFT is 0.
  localparam logic signed [ACC_W:0] RND = ((ACC_W + 1)'(1) << SHIFT) >> 1;

  // Output clip limits expressed at the one-bit-extended accumulator width.
  localparam logic signed [ACC_W:0] OUT_MAX =
    {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [1:0]               state;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic                     ready_q;

  logic signed [DATA_W-1:0] delay_line [NUM_TAPS];
  logic signed [COEF_W-1:0] coef       [NUM_TAPS];

  logic                     in_fire;
  logic                     coef_fire;
  logic                     mac_last;
  logic                     idle_next;

  logic [AW:0]              idx_wide;
  logic [AW-1:0]            rd_idx;
  logic signed [DATA_W-1:0] delay_rd;
  logic signed [COEF_W-1:0] coef_rd;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    sum_ext;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic signed [ACC_W:0]    clipped;
  logic                     clip_hit;

  assign in_fire   = (state == S_IDLE) && in_valid && ready_q;
  assign coef_fire = coef_we && (state == S_IDLE) && ({1'b0, coef_addr} < TAPS_EXT);
  assign mac_last  = (state == S_MAC) && (k == LAST_TAP);
  assign idle_next = ((state == S_IDLE) && !in_fire) ||
                     ((state == S_OUT) && out_ready);

  assign in_ready  = ready_q;
  assign out_valid = (state == S_OUT);
  assign busy      = (state == S_MAC) || (state == S_OUT);

  // Tap k reads the sample written k acceptances ago: (wr_ptr - k) mod NUM_TAPS.
  always_comb begin
    idx_wide = {1'b0, wr_ptr} + TAPS_EXT - {1'b0, k};
    if (idx_wide >= TAPS_EXT) begin
      idx_wide = idx_wide - TAPS_EXT;
    end
    rd_idx = idx_wide[AW-1:0];
  end

  assign delay_rd = delay_line[rd_idx];
  assign coef_rd  = coef[k];

  // MAC datapath plus the round, arithmetic shift and clip of the final sum.
  always_comb begin
    prod     = PW'(delay_rd) * PW'(coef_rd);
    acc_sum  = acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
    sum_ext  = {acc_sum[ACC_W-1], acc_sum};
    rounded  = sum_ext + RND;
    shifted  = rounded >>> SHIFT;
    clipped  = shifted;
    clip_hit = 1'b0;
    if (shifted > OUT_MAX) begin
      clipped  = OUT_MAX;
      clip_hit = 1'b1;
    end else if (shifted < OUT_MIN) begin
      clipped  = OUT_MIN;
      clip_hit = 1'b1;
    end
  end

  // Control FSM: tap counter, write pointer and accumulator sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      wr_ptr <= '0;
      acc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_fire) begin
            state <= S_MAC;
            k     <= '0;
            acc   <= '0;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          if (k == LAST_TAP) begin
            state  <= S_OUT;
            k      <= '0;
            wr_ptr <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + AW'(1);
          end else begin
            k <= k + AW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // in_ready is registered so it rises on the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= idle_next;
    end
  end

  // Circular delay line: each accepted sample overwrites the oldest slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        delay_line[i] <= '0;
      end
    end else if (in_fire) begin
      delay_line[wr_ptr] <= in_data;
    end
  end

  // Coefficient register file, writable only while idle and in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef[i] <= '0;
      end
    end else if (coef_fire) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Capture the scaled result and saturation flag on the last MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      sat      <= 1'b0;
    end else if (mac_last) begin
      out_data <= clipped[OUT_W-1:0];
      sat      <= clip_hit;
    end
  end

endmodule

// File: tb/tb_fir_seq_mac.sv
// tb_fir_seq_mac: directed bench for fir_seq_mac. Instance "a" uses the
// default Q15 configuration, instance "b" uses OUT_W=32, SHIFT=0 so raw
// integer sums are visible.
module tb_fir_seq_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic               a_rst, a_coef_we, a_in_valid, a_out_ready;
  logic               a_in_ready, a_out_valid, a_sat, a_busy;
  logic [3:0]         a_coef_addr;
  logic signed [15:0] a_coef_data, a_in_data, a_out_data;

  logic               b_rst, b_coef_we, b_in_valid, b_out_ready;
  logic               b_in_ready, b_out_valid, b_sat, b_busy;
  logic [3:0]         b_coef_addr;
  logic signed [15:0] b_coef_data, b_in_data;
  logic signed [31:0] b_out_data;

  fir_seq_mac u_dflt (
    .clk(clk), .rst(a_rst), .coef_we(a_coef_we), .coef_addr(a_coef_addr),
    .coef_data(a_coef_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .sat(a_sat), .busy(a_busy)
  );

  fir_seq_mac #(.OUT_W(32), .SHIFT(0)) u_wide (
    .clk(clk), .rst(b_rst), .coef_we(b_coef_we), .coef_addr(b_coef_addr),
    .coef_data(b_coef_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .sat(b_sat), .busy(b_busy)
  );

  typedef struct {
    int     h0;
    int     x;
    longint exp_out;
    logic   exp_sat;
  } vec_t;

  vec_t tbl [9];

  function automatic logic rdy(bit s);   return s ? b_in_ready  : a_in_ready;  endfunction
  function automatic logic ovld(bit s);  return s ? b_out_valid : a_out_valid; endfunction
  function automatic logic osat(bit s);  return s ? b_sat       : a_sat;       endfunction
  function automatic logic obusy(bit s); return s ? b_busy      : a_busy;      endfunction
  function automatic longint odata(bit s);
    return s ? longint'(b_out_data) : longint'(a_out_data);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(string name, longint actual, longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic drive_in(bit s, logic v, int d);
    if (s) begin b_in_valid = v; b_in_data = 16'(d); end
    else   begin a_in_valid = v; a_in_data = 16'(d); end
  endtask

  task automatic drive_coef(bit s, logic we, int addr, int d);
    if (s) begin b_coef_we = we; b_coef_addr = 4'(addr); b_coef_data = 16'(d); end
    else   begin a_coef_we = we; a_coef_addr = 4'(addr); a_coef_data = 16'(d); end
  endtask

  task automatic set_rst(bit s, logic r);
    if (s) b_rst = r; else a_rst = r;
  endtask

  task automatic set_out_ready(bit s, logic r);
    if (s) b_out_ready = r; else a_out_ready = r;
  endtask

  task automatic write_coef(bit s, int addr, int d);
    drive_coef(s, 1'b1, addr, d);
    tick();
    drive_coef(s, 1'b0, 0, 0);
  endtask

  task automatic wait_ready(bit s);
    int n = 0;
    while (!rdy(s) && n < 200) begin tick(); n++; end
    check_value("in_ready_wait", longint'(rdy(s)), 1);
  endtask

  task automatic wait_valid(bit s, output int lat);
    lat = 0;
    while (!ovld(s) && lat < 200) begin tick(); lat++; end
  endtask

  // Present one sample, then count edges after acceptance until out_valid.
  task automatic applyStimulus(bit s, int x, output int lat);
    wait_ready(s);
    drive_in(s, 1'b1, x);
    tick();
    drive_in(s, 1'b0, 0);
    wait_valid(s, lat);
  endtask

  // Compare the held result, then let the handshake edge pass.
  task automatic checkOutput(bit s, string name, longint exp_out, logic exp_sat);
    check_value({name, ".valid"}, longint'(ovld(s)), 1);
    check_value({name, ".data"}, odata(s), exp_out);
    check_value({name, ".sat"}, longint'(osat(s)), longint'(exp_sat));
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;

    tbl[0] = '{16384,   1000,    500, 1'b0};
    tbl[1] = '{16384,     -3,     -1, 1'b0};
    tbl[2] = '{16384,      3,      2, 1'b0};
    tbl[3] = '{16384,      1,      1, 1'b0};
    tbl[4] = '{16384,     -1,      0, 1'b0};
    tbl[5] = '{32767,  32767,  32766, 1'b0};
    tbl[6] = '{-32768, -32768, 32767, 1'b1};
    tbl[7] = '{-32768, 32767, -32767, 1'b0};
    tbl[8] = '{0,      12345,      0, 1'b0};

    a_rst = 1'b1; b_rst = 1'b1;
    drive_in(0, 1'b0, 0); drive_in(1, 1'b0, 0);
    drive_coef(0, 1'b0, 0, 0); drive_coef(1, 1'b0, 0, 0);
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    tick(); tick();

    $display("[TB] reset state");
    for (int s = 0; s < 2; s++) begin
      check_value($sformatf("rst_valid[%0d]", s), longint'(ovld(s[0])), 0);
      check_value($sformatf("rst_ready[%0d]", s), longint'(rdy(s[0])), 0);
      check_value($sformatf("rst_data[%0d]", s), odata(s[0]), 0);
      check_value($sformatf("rst_sat[%0d]", s), longint'(osat(s[0])), 0);
      check_value($sformatf("rst_busy[%0d]", s), longint'(obusy(s[0])), 0);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    check_value("post_rst_ready_a", longint'(a_in_ready), 1);
    check_value("post_rst_ready_b", longint'(b_in_ready), 1);

    $display("[TB] rounding and single-tap table");
    for (int i = 0; i < 9; i++) begin
      write_coef(0, 0, tbl[i].h0);
      applyStimulus(0, tbl[i].x, lat);
      check_value($sformatf("tbl_lat[%0d]", i), lat, 11);
      checkOutput(0, $sformatf("tbl[%0d]", i), tbl[i].exp_out, tbl[i].exp_sat);
    end

    $display("[TB] saturation");
    for (int k = 0; k < 11; k++) write_coef(0, k, 32767);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, 32767, lat);
      if (i == 10) checkOutput(0, "sat_pos", 32767, 1'b1);
    end
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, -32768, lat);
      if (i == 10) checkOutput(0, "sat_neg", -32768, 1'b1);
    end

    $display("[TB] backpressure");
    set_out_ready(0, 1'b0);
    applyStimulus(0, -32768, lat);
    drive_in(0, 1'b1, 5);
    for (int c = 0; c < 5; c++) begin
      check_value($sformatf("bp_valid[%0d]", c), longint'(a_out_valid), 1);
      check_value($sformatf("bp_data[%0d]", c), longint'(a_out_data), -32768);
      check_value($sformatf("bp_sat[%0d]", c), longint'(a_sat), 1);
      check_value($sformatf("bp_ready[%0d]", c), longint'(a_in_ready), 0);
      tick();
    end
    drive_in(0, 1'b0, 0);
    set_out_ready(0, 1'b1);
    tick();
    check_value("bp_after_valid", longint'(a_out_valid), 0);
    check_value("bp_after_ready", longint'(a_in_ready), 1);
    check_value("bp_after_busy", longint'(a_busy), 0);

    $display("[TB] coefficient gating");
    set_rst(0, 1'b1); tick(); set_rst(0, 1'b0); tick();
    write_coef(0, 0, 50);
    wait_ready(0);
    drive_in(0, 1'b1, 1000);
    tick();
    drive_in(0, 1'b0, 0);
    tick(); tick();
    check_value("gate_busy", longint'(a_busy), 1);
    write_coef(0, 0, 100);
    wait_valid(0, lat);
    checkOutput(0, "gate_during_mac", 2, 1'b0);
    applyStimulus(0, 1000, lat);
    checkOutput(0, "gate_old_h0", 2, 1'b0);
    wait_ready(0);
    drive_coef(0, 1'b1, 0, 100);
    drive_in(0, 1'b1, 1000);
    tick();
    drive_coef(0, 1'b0, 0, 0);
    drive_in(0, 1'b0, 0);
    wait_valid(0, lat);
    checkOutput(0, "gate_same_cycle", 3, 1'b0);
    write_coef(0, 11, 32767);
    applyStimulus(0, 1000, lat);
    checkOutput(0, "gate_addr_oob", 3, 1'b0);

    $display("[TB] impulse response");
    for (int k = 0; k < 11; k++) write_coef(1, k, k + 1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, (i == 0) ? 1 : 0, lat);
      check_value($sformatf("imp_lat[%0d]", i), lat, 11);
      checkOutput(1, $sformatf("imp[%0d]", i), (i < 11) ? longint'(i + 1) : 0, 1'b0);
    end

    $display("[TB] reset during MAC");
    wait_ready(1);
    drive_in(1, 1'b1, 7);
    tick();
    drive_in(1, 1'b0, 0);
    repeat (5) tick();
    check_value("mid_busy", longint'(b_busy), 1);
    set_rst(1, 1'b1);
    #1;
    check_value("mid_rst_valid", longint'(b_out_valid), 0);
    check_value("mid_rst_ready", longint'(b_in_ready), 0);
    check_value("mid_rst_busy", longint'(b_busy), 0);
    tick();
    check_value("mid_rst_ready_held", longint'(b_in_ready), 0);
    set_rst(1, 1'b0);
    tick();
    check_value("mid_post_ready", longint'(b_in_ready), 1);
    applyStimulus(1, 1, lat);
    checkOutput(1, "mid_coef_cleared", 0, 1'b0);
    for (int k = 0; k < 11; k++) write_coef(1, k, 1);
    applyStimulus(1, 0, lat);
    checkOutput(1, "mid_no_residue", 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
